// File: rtl/sigma_delta_cic_decimator.sv
// Third-order CIC decimator for a 1-bit sigma-delta stream.
// Single-entry output register with valid/ready and a sticky overrun flag.
module sigma_delta_cic_decimator #(
    parameter int R_LOG2   = 6,
    parameter int N_STAGES = 3,
    parameter int OUT_W    = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             i_enable,
    input  logic             i_bit,
    input  logic             i_bit_valid,
    output logic [OUT_W-1:0] o_sample,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_overrun,
    input  logic             i_clr_overrun
);

    localparam int ACC_W = 3 * R_LOG2 + 2;

    logic [ACC_W-1:0]  integ     [N_STAGES];
    logic [ACC_W-1:0]  integ_nxt [N_STAGES];
    logic [ACC_W-1:0]  dly       [N_STAGES];
    logic [ACC_W-1:0]  comb      [N_STAGES];
    logic [ACC_W-1:0]  x;
    logic [R_LOG2-1:0] cnt;
    logic [OUT_W-1:0]  samp_nxt;
    logic              accept;
    logic              dec_pt;
    logic              blocked;

    assign accept  = i_enable & i_bit_valid;
    assign dec_pt  = accept & (&cnt);
    assign blocked = o_valid & ~i_ready;
    assign x = i_bit ? {{(ACC_W-1){1'b0}}, 1'b1} : {ACC_W{1'b1}};

    // Integrators cascade within the cycle; combs see the updated last stage.
    always_comb begin
        for (int k = 0; k < N_STAGES; k++) begin
            integ_nxt[k] = '0;
            comb[k]      = '0;
        end
        integ_nxt[0] = integ[0] + x;
        for (int k = 1; k < N_STAGES; k++)
            integ_nxt[k] = integ[k] + integ_nxt[k-1];
        comb[0] = integ_nxt[N_STAGES-1] - dly[0];
        for (int k = 1; k < N_STAGES; k++)
            comb[k] = comb[k-1] - dly[k];
    end

    generate
        if (OUT_W <= ACC_W) begin : g_trunc
            assign samp_nxt = comb[N_STAGES-1][ACC_W-1 -: OUT_W];
        end else begin : g_align
            assign samp_nxt = {comb[N_STAGES-1], {(OUT_W-ACC_W){1'b0}}};
        end
    endgenerate

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int k = 0; k < N_STAGES; k++) begin
                integ[k] <= '0;
                dly[k]   <= '0;
            end
            cnt <= '0;
        end else if (!i_enable) begin
            for (int k = 0; k < N_STAGES; k++) begin
                integ[k] <= '0;
                dly[k]   <= '0;
            end
            cnt <= '0;
        end else if (accept) begin
            for (int k = 0; k < N_STAGES; k++)
                integ[k] <= integ_nxt[k];
            cnt <= cnt + 1'b1;
            if (dec_pt) begin
                dly[0] <= integ_nxt[N_STAGES-1];
                for (int k = 1; k < N_STAGES; k++)
                    dly[k] <= comb[k-1];
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            o_sample <= '0;
            o_valid  <= 1'b0;
        end else if (!i_enable) begin
            o_valid <= 1'b0;
        end else if (dec_pt && !blocked) begin
            o_sample <= samp_nxt;
            o_valid  <= 1'b1;
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end
    end

    // A dropped sample wins over a same-cycle clear request.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            o_overrun <= 1'b0;
        else if (i_enable && dec_pt && blocked)
            o_overrun <= 1'b1;
        else if (i_clr_overrun)
            o_overrun <= 1'b0;
    end

endmodule
